gf2_min_solve: RTL and testbench
================================

Name: gf2_min_solve

Overview:
Consumer end of the GF(2) elimination path: accepts a matrix already in reduced row-echelon form, as produced by gf2_rref, and extracts the minimum-Hamming-weight solution vector.
- Scans rows to find pivots and detect inconsistency.
- Enumerates every free-variable assignment, one candidate per cycle, keeping the lightest.
- Feeds the per-machine "fewest button presses" result to the puzzle accumulator.

Parameters:
MAX_ROWS, 4, maximum equation rows
MAX_COLS, 7, maximum columns including RHS; variable count NVAR = cols-1, at most MAX_COLS-1

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
rows  in  ROWS_W=$clog2(MAX_ROWS+1)  active row count; sampled with start
cols  in  COLS_W=$clog2(MAX_COLS+1)  active column count incl. RHS; sampled with start
start  in  1  request; accepted only when ready=1
RREF  in  MAX_COLS x MAX_ROWS (unpacked array)  bit j<cols-1 = coefficient of x_j, bit cols-1 = RHS; sampled with start
ready  out  1  idle, may accept start
done  out  1  one-cycle completion pulse
solvable  out  1  system consistent
solution  out  MAX_COLS-1  minimum-weight assignment, bit j = x_j
weight  out  $clog2(MAX_COLS)  popcount(solution)

Behaviour:
- Reset values: ready=1, done=0, solvable=0, solution=0, weight=0; FSM=IDLE.
- IDLE:
  - On start&ready (edge T), latch RREF, rows, cols, clear pivot mask and best; go to SCAN.
  - start while not ready is ignored.
- SCAN (cycles T+1..T+rows; zero cycles if rows=0), one row per cycle:
  - Pivot = lowest-index set bit in [cols-2:0]; record it and set its bit in pivot mask.
  - Row with zero coefficients and RHS=1 sets inconsistent.
  - Rows >= rows are ignored; bits >= cols are ignored.
- After SCAN:
  - If inconsistent: go to DONE with solvable=0, solution=0, weight=0.
  - Otherwise: free mask = ~pivot & valid-variable mask; nfree = popcount; candidate counter k=0; go to ENUM.
- ENUM, one candidate per cycle, k = 0..2^nfree-1:
  - f = k bits deposited into free positions, LSB of k into lowest free index.
  - Each pivot row r: x_piv(r) = RHS(r) ^ parity(row_r & free mask & f).
  - Candidate = f | pivot values; weight = popcount(candidate).
  - Update best only when weight is strictly less than the current best (first-found wins ties). k=0 always loads best.
  - After the last k, go to DONE.
- NVAR=0: exactly one empty candidate.
- DONE: done=1 for one cycle; solvable/solution/weight registered and held until the next accepted start; ready=1 again the following cycle.
- Latency from accept edge T to the done cycle:
  - Consistent: T + rows + 2^nfree + 1.
  - Inconsistent: T + rows + 1.
- Reset mid-operation: immediate return to reset values; no done pulse.
- Counter width NVAR+1 bits so 2^NVAR is terminable without wrap.

Optional Feature:
GF2_MIN_SOLVE_STATS_EN
- Defined: adds outputs nfree ($clog2(MAX_COLS) bits) and cand_cnt (MAX_COLS bits, number of candidates evaluated). Both are registered at done, held with the other results, and reset to 0.
- Undefined: ports and logic absent; all other behaviour identical.

Decomposition:
- Package gf2_pkg: ROWS_W/COLS_W width functions, FSM state enum (IDLE, SCAN, ENUM, DONE), popcount and parity functions.
- One sub-module gf2_bit_deposit: combinational, packs counter bits into free-mask positions (pdep), parameterised by width.

Test Plan:
1. cols=4, rows=3, RREF={1001,0010,1100} (row0..2, bit3 = RHS) -> solvable=1, solution=101, weight=2, nfree=0, done at T+5.
2. cols=4, rows=2, RREF={1001,1000} -> solvable=0, solution=0, weight=0, done at T+3, ENUM skipped.
3. cols=4, rows=2, RREF={1101,0110} (x2 free) -> solution=001, weight=1, 2 candidates, done at T+5.
4. cols=3, rows=1, RREF={111} (tie) -> solution=01, weight=1; first-found kept, not 10.
5. cols=7, rows=4, all-zero -> 64 candidates, solution=0, weight=0, solvable=1, done at T+69; start pulses during ENUM ignored.
6. Assert rst_n low mid-ENUM of case 5 -> ready=1, outputs 0, no done pulse; a following start of case 1 completes correctly.

Source files
------------

// File: rtl/gf2_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : gf2_pkg
//  Purpose : Shared definitions for the GF(2) minimum-weight solver. Holds the
//            port-width helpers, the solver state encoding, and the popcount
//            and parity helpers.
//  Ports   : none (package)
//  Rev     : 1.0  initial release
// ============================================================================
package gf2_pkg;

    // Widest vector the bit helpers accept. Callers zero-extend into it.
    localparam int VEC_W = 32;

    // Width that can hold a row count 0..max_rows.
    function automatic int rows_width(input int max_rows);
        return $clog2(max_rows + 1);
    endfunction

    // Width that can hold a column count 0..max_cols.
    function automatic int cols_width(input int max_cols);
        return $clog2(max_cols + 1);
    endfunction

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        ENUM = 2'd2,
        DONE = 2'd3
    } state_t;

    function automatic logic [5:0] popcount(input logic [VEC_W-1:0] v);
        logic [5:0] n;
        n = '0;
        for (int i = 0; i < VEC_W; i++) begin
            n = n + 6'(v[i]);
        end
        return n;
    endfunction

    function automatic logic parity(input logic [VEC_W-1:0] v);
        return ^v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/gf2_bit_deposit.sv
`default_nettype none
// ============================================================================
//  Module  : gf2_bit_deposit
//  Purpose : Combinational parallel bit deposit. The low-order bits of src are
//            scattered, in order, into the set positions of mask (LSB of src
//            lands in the lowest set mask bit). Unmasked positions read 0.
//  Ports   : src  [WIDTH]  packed source bits
//            mask [WIDTH]  destination positions
//            dst  [WIDTH]  deposited result
//  Rev     : 1.0  initial release
// ============================================================================
module gf2_bit_deposit #(
    parameter int WIDTH = 6
) (
    input  logic [WIDTH-1:0] src,
    input  logic [WIDTH-1:0] mask,
    output logic [WIDTH-1:0] dst
);

    // Remaining source bits; consumed from the bottom as mask positions fill.
    logic [WIDTH-1:0] rem;

    always_comb begin
        dst = '0;
        rem = src;
        for (int i = 0; i < WIDTH; i++) begin
            if (mask[i]) begin
                dst[i] = rem[0];
                rem    = rem >> 1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/gf2_min_solve.sv
`default_nettype none
// ============================================================================
//  Module  : gf2_min_solve
//  Purpose : Takes a GF(2) system already in reduced row-echelon form and
//            finds its minimum-Hamming-weight solution. Rows are scanned one
//            per cycle to locate pivots and detect a 0 = 1 row; then every
//            free-variable assignment is evaluated, one per cycle, and the
//            lightest (first found on ties) is kept.
//  Ports   : clk, rst_n          clock, asynchronous active-low reset
//            rows, cols          active row / column count (cols incl. RHS)
//            start               request, accepted only while ready
//            RREF[MAX_ROWS]      rows; bit j<cols-1 = coeff x_j, bit cols-1 = RHS
//            ready               idle
//            done                one-cycle completion pulse
//            solvable            system consistent
//            solution            minimum-weight assignment, bit j = x_j
//            weight              popcount(solution)
//  Option  : GF2_MIN_SOLVE_STATS_EN adds outputs nfree (free variable count)
//            and cand_cnt (candidates evaluated), registered at done.
//  Rev     : 1.0  initial release
// ============================================================================
module gf2_min_solve
    import gf2_pkg::*;
#(
    parameter  int MAX_ROWS = 4,
    parameter  int MAX_COLS = 7,
    localparam int ROWS_W   = rows_width(MAX_ROWS),
    localparam int COLS_W   = cols_width(MAX_COLS),
    localparam int NV       = MAX_COLS - 1,
    localparam int WT_W     = $clog2(MAX_COLS)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [ROWS_W-1:0]   rows,
    input  logic [COLS_W-1:0]   cols,
    input  logic                start,
    input  logic [MAX_COLS-1:0] RREF [MAX_ROWS],
    output logic                ready,
    output logic                done,
    output logic                solvable,
    output logic [NV-1:0]       solution,
    output logic [WT_W-1:0]     weight
`ifdef GF2_MIN_SOLVE_STATS_EN
    ,
    output logic [WT_W-1:0]     nfree,
    output logic [MAX_COLS-1:0] cand_cnt
`endif
);

    // ------------------------------------------------------------------
    // Registered state
    // ------------------------------------------------------------------
    state_t              state;
    state_t              state_nxt;
    logic [MAX_COLS-1:0] rref_q  [MAX_ROWS];
    logic [NV-1:0]       piv_oh  [MAX_ROWS];   // one-hot pivot per row, 0 if none
    logic [ROWS_W-1:0]   rows_q;
    logic [COLS_W-1:0]   cols_q;
    logic [ROWS_W-1:0]   row_idx;
    logic [NV-1:0]       piv_mask;
    logic                incons;
    logic [MAX_COLS-1:0] k;                    // NV+1 bits: 2^NV is reachable
    logic [NV-1:0]       best_sol;
    logic [WT_W-1:0]     best_wt;

    // ------------------------------------------------------------------
    // Request sampling: counts above the hardware maximum are clamped
    // ------------------------------------------------------------------
    logic [ROWS_W-1:0] rows_in;
    logic [COLS_W-1:0] cols_in;
    logic              accept;

    assign rows_in = (int'(rows) > MAX_ROWS) ? ROWS_W'(MAX_ROWS) : rows;
    assign cols_in = (int'(cols) > MAX_COLS) ? COLS_W'(MAX_COLS) : cols;
    assign accept  = (state == IDLE) && start;

    // ------------------------------------------------------------------
    // Column masks from the latched column count
    // ------------------------------------------------------------------
    logic [MAX_COLS-1:0] rhs_oh;
    logic [NV-1:0]       var_mask;

    always_comb begin
        rhs_oh   = '0;
        var_mask = '0;
        if (cols_q != '0) begin
            rhs_oh   = MAX_COLS'(1) << (cols_q - COLS_W'(1));
            var_mask = NV'(rhs_oh - MAX_COLS'(1));
        end
    end

    // ------------------------------------------------------------------
    // Row scan
    // ------------------------------------------------------------------
    logic [MAX_COLS-1:0] cur_row;
    logic [NV-1:0]       cur_coef;
    logic [NV-1:0]       cur_piv;
    logic                cur_rhs;
    logic                cur_bad;
    logic                incons_nxt;
    logic                last_row;

    always_comb begin
        cur_row = '0;
        for (int r = 0; r < MAX_ROWS; r++) begin
            if (row_idx == ROWS_W'(r)) begin
                cur_row = rref_q[r];
            end
        end
    end

    assign cur_coef   = cur_row[NV-1:0] & var_mask;
    // Two's-complement trick isolates the lowest set coefficient.
    assign cur_piv    = cur_coef & (~cur_coef + NV'(1));
    assign cur_rhs    = |(cur_row & rhs_oh);
    assign cur_bad    = (cur_coef == '0) && cur_rhs;
    assign incons_nxt = incons | cur_bad;
    assign last_row   = (row_idx == rows_q - ROWS_W'(1));

    // ------------------------------------------------------------------
    // Candidate evaluation
    // ------------------------------------------------------------------
    logic [NV-1:0]       free_mask;
    logic [WT_W-1:0]     nfree_cnt;
    logic                k_last;
    logic [NV-1:0]       free_val;
    logic [NV-1:0]       cand;
    logic                xv;
    logic [WT_W-1:0]     cand_wt;
    logic                take;
    logic [NV-1:0]       sel_sol;
    logic [WT_W-1:0]     sel_wt;

    assign free_mask = ~piv_mask & var_mask;
    assign nfree_cnt = WT_W'(popcount(VEC_W'(free_mask)));
    assign k_last    = (k == ((MAX_COLS'(1) << nfree_cnt) - MAX_COLS'(1)));

    gf2_bit_deposit #(
        .WIDTH (NV)
    ) u_deposit (
        .src  (k[NV-1:0]),
        .mask (free_mask),
        .dst  (free_val)
    );

    // Each pivot variable is forced by its row: RHS xor the free terms.
    // Pivot and free positions are disjoint, so OR merges them.
    always_comb begin
        cand = free_val;
        xv   = 1'b0;
        for (int r = 0; r < MAX_ROWS; r++) begin
            xv   = (|(rref_q[r] & rhs_oh))
                 ^ parity(VEC_W'(rref_q[r][NV-1:0] & free_mask & free_val));
            cand = cand | (piv_oh[r] & {NV{xv}});
        end
    end

    assign cand_wt = WT_W'(popcount(VEC_W'(cand)));
    assign take    = (k == '0) || (cand_wt < best_wt);
    assign sel_sol = take ? cand    : best_sol;
    assign sel_wt  = take ? cand_wt : best_wt;

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = (rows_in == '0) ? ENUM : SCAN;
                end
            end
            SCAN: begin
                if (last_row) begin
                    state_nxt = incons_nxt ? DONE : ENUM;
                end
            end
            ENUM: begin
                if (k_last) begin
                    state_nxt = DONE;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign ready = (state == IDLE);
    assign done  = (state == DONE);

    // ------------------------------------------------------------------
    // Datapath and result registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < MAX_ROWS; r++) begin
                rref_q[r] <= '0;
                piv_oh[r] <= '0;
            end
            rows_q   <= '0;
            cols_q   <= '0;
            row_idx  <= '0;
            piv_mask <= '0;
            incons   <= 1'b0;
            k        <= '0;
            best_sol <= '0;
            best_wt  <= '0;
            solvable <= 1'b0;
            solution <= '0;
            weight   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        for (int r = 0; r < MAX_ROWS; r++) begin
                            rref_q[r] <= RREF[r];
                            piv_oh[r] <= '0;
                        end
                        rows_q   <= rows_in;
                        cols_q   <= cols_in;
                        row_idx  <= '0;
                        piv_mask <= '0;
                        incons   <= 1'b0;
                        k        <= '0;
                        best_sol <= '0;
                        best_wt  <= '0;
                        solvable <= 1'b0;
                        solution <= '0;
                        weight   <= '0;
                    end
                end
                SCAN: begin
                    for (int r = 0; r < MAX_ROWS; r++) begin
                        if (row_idx == ROWS_W'(r)) begin
                            piv_oh[r] <= cur_piv;
                        end
                    end
                    piv_mask <= piv_mask | cur_piv;
                    incons   <= incons_nxt;
                    row_idx  <= row_idx + ROWS_W'(1);
                end
                ENUM: begin
                    k        <= k + MAX_COLS'(1);
                    best_sol <= sel_sol;
                    best_wt  <= sel_wt;
                    if (k_last) begin
                        solvable <= 1'b1;
                        solution <= sel_sol;
                        weight   <= sel_wt;
                    end
                end
                default: begin
                end
            endcase
        end
    end

`ifdef GF2_MIN_SOLVE_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            nfree    <= '0;
            cand_cnt <= '0;
        end else if (accept) begin
            nfree    <= '0;
            cand_cnt <= '0;
        end else if ((state == ENUM) && k_last) begin
            nfree    <= nfree_cnt;
            cand_cnt <= k + MAX_COLS'(1);
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_gf2_min_solve.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module  : tb_gf2_min_solve
//  Purpose : Self-checking bench for gf2_min_solve. Expected results come from
//            a brute-force solver over all assignments, tie-broken by the
//            packed free-variable index.
//  Rev     : 1.0  initial release
// ============================================================================
module tb_gf2_min_solve;

    localparam int MR = 4;
    localparam int MC = 7;
    localparam int NV = MC - 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [2:0]    rows;
    logic [2:0]    cols;
    logic          start;
    logic [MC-1:0] rref_v [MR];
    logic          ready;
    logic          done;
    logic          solvable;
    logic [NV-1:0] solution;
    logic [2:0]    weight;
`ifdef GF2_MIN_SOLVE_STATS_EN
    logic [2:0]    nfree_o;
    logic [MC-1:0] cand_cnt_o;
`endif

    always #5 clk = ~clk;

    gf2_min_solve #(
        .MAX_ROWS (MR),
        .MAX_COLS (MC)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .rows     (rows),
        .cols     (cols),
        .start    (start),
        .RREF     (rref_v),
        .ready    (ready),
        .done     (done),
        .solvable (solvable),
        .solution (solution),
        .weight   (weight)
`ifdef GF2_MIN_SOLVE_STATS_EN
        ,
        .nfree    (nfree_o),
        .cand_cnt (cand_cnt_o)
`endif
    );

    int total = 0;
    int bad   = 0;

    // reference results
    int m_solv, m_sol, m_wt, m_nfree;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int pext(input int x, input int m);
        int r, j;
        r = 0;
        j = 0;
        for (int i = 0; i < NV; i++) begin
            if (((m >> i) & 1) == 1) begin
                r = r | (((x >> i) & 1) << j);
                j++;
            end
        end
        return r;
    endfunction

    // Brute force: try every assignment, keep the lightest solution and on
    // equal weight the one whose packed free-variable value is smallest.
    task automatic model(input int r_n, input int c_n);
        int nvar, vmask, pm, freem, ok, key, best_key, w, row, lhs, rhs;
        nvar  = c_n - 1;
        vmask = (1 << nvar) - 1;
        pm    = 0;
        for (int i = 0; i < r_n; i++) begin
            row = int'(rref_v[i]) & vmask;
            if (row != 0) pm = pm | (row & -row);
        end
        freem    = vmask & ~pm;
        m_nfree  = $countones(freem);
        m_solv   = 0;
        m_sol    = 0;
        m_wt     = 0;
        best_key = 0;
        for (int x = 0; x < (1 << nvar); x++) begin
            ok = 1;
            for (int i = 0; i < r_n; i++) begin
                rhs = (int'(rref_v[i]) >> nvar) & 1;
                lhs = $countones(int'(rref_v[i]) & vmask & x) & 1;
                if (lhs != rhs) ok = 0;
            end
            if (ok == 1) begin
                key = pext(x, freem);
                w   = $countones(x);
                if (m_solv == 0 || w < m_wt || (w == m_wt && key < best_key)) begin
                    m_solv   = 1;
                    m_sol    = x;
                    m_wt     = w;
                    best_key = key;
                end
            end
        end
    endtask

    // Random genuine RREF with junk above cols and in unused rows.
    task automatic gen(output int r_n, output int c_n);
        int nvar, npiv, pm, v;
        int piv [MR];
        nvar = $urandom_range(0, 6);
        c_n  = nvar + 1;
        r_n  = $urandom_range(0, 4);
        pm   = 0;
        npiv = 0;
        for (int i = 0; i < MR; i++) piv[i] = 0;
        for (int c = 0; c < nvar; c++) begin
            if (npiv < r_n && $urandom_range(0, 1) == 1) begin
                pm = pm | (1 << c);
                piv[npiv] = c;
                npiv++;
            end
        end
        for (int i = 0; i < MR; i++) begin
            if (i < npiv) begin
                v = 1 << piv[i];
                for (int c = piv[i] + 1; c < nvar; c++) begin
                    if (((pm >> c) & 1) == 0 && $urandom_range(0, 1) == 1) v = v | (1 << c);
                end
                if ($urandom_range(0, 1) == 1) v = v | (1 << nvar);
                v = v | (int'($urandom) & ~((1 << c_n) - 1));
            end else if (i < r_n) begin
                v = ($urandom_range(0, 3) == 0) ? (1 << nvar) : 0;
                v = v | (int'($urandom) & ~((1 << c_n) - 1));
            end else begin
                v = int'($urandom);
            end
            rref_v[i] = MC'(v);
        end
    endtask

    // Issue one request, measure latency, check results against the model.
    task automatic run_case(input string tag, input int r_n, input int c_n, input int poke_at);
        int  n, exp_n;
        bit  seen;
        model(r_n, c_n);
        exp_n = r_n + ((m_solv == 1) ? (1 << m_nfree) : 0);
        n = 0;
        while (ready !== 1'b1 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        chk({tag, ".ready"}, 32'(ready), 1);
        @(negedge clk);
        rows  = 3'(r_n);
        cols  = 3'(c_n);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        // inputs must have been latched: scramble them
        rows = 3'($urandom);
        cols = 3'($urandom);
        for (int i = 0; i < MR; i++) rref_v[i] = MC'($urandom);
        chk({tag, ".busy"}, 32'(ready), 0);
        n    = 0;
        seen = 1'b0;
        while (!seen && n < 300) begin
            start = (poke_at > 0 && n == poke_at) ? 1'b1 : 1'b0;
            @(posedge clk); #1;
            n++;
            seen = (done === 1'b1);
        end
        start = 1'b0;
        chk({tag, ".latency"}, 32'(n), 32'(exp_n));
        chk({tag, ".solvable"}, 32'(solvable), 32'(m_solv));
        chk({tag, ".solution"}, 32'(solution), 32'(m_sol));
        chk({tag, ".weight"}, 32'(weight), 32'(m_wt));
`ifdef GF2_MIN_SOLVE_STATS_EN
        chk({tag, ".nfree"}, 32'(nfree_o), (m_solv == 1) ? 32'(m_nfree) : 0);
        chk({tag, ".cand_cnt"}, 32'(cand_cnt_o), (m_solv == 1) ? 32'(1 << m_nfree) : 0);
`endif
        @(posedge clk); #1;
        chk({tag, ".pulse"}, 32'(done), 0);
        chk({tag, ".hold"}, 32'(solution), 32'(m_sol));
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "timeout");
    end

    initial begin : stim
        int  r_n, c_n;
        bit  saw;
        rst_n = 1'b0;
        start = 1'b0;
        rows  = '0;
        cols  = '0;
        for (int i = 0; i < MR; i++) rref_v[i] = '0;
        #2;
        chk("reset.ready", 32'(ready), 1);
        chk("reset.done", 32'(done), 0);
        chk("reset.solvable", 32'(solvable), 0);
        chk("reset.solution", 32'(solution), 0);
        chk("reset.weight", 32'(weight), 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // 1: unique solution, no free variables
        rref_v[0] = 7'b0001001;
        rref_v[1] = 7'b1010010;
        rref_v[2] = 7'b0001100;
        rref_v[3] = 7'b1111111;
        run_case("c1", 3, 4, 0);
        chk("c1.const_sol", 32'(solution), 32'h5);
        chk("c1.const_wt", 32'(weight), 2);

        // 2: 0 = 1 row
        rref_v[0] = 7'b0001001;
        rref_v[1] = 7'b0001000;
        run_case("c2", 2, 4, 0);
        chk("c2.const_solv", 32'(solvable), 0);

        // 3: one free variable
        rref_v[0] = 7'b0001101;
        rref_v[1] = 7'b0000110;
        run_case("c3", 2, 4, 0);
        chk("c3.const_sol", 32'(solution), 32'h1);

        // 4: weight tie, first-found kept
        rref_v[0] = 7'b0000111;
        run_case("c4", 1, 3, 0);
        chk("c4.const_sol", 32'(solution), 32'h1);

        // 5: all free, stray start during enumeration
        for (int i = 0; i < MR; i++) rref_v[i] = '0;
        run_case("c5", 4, 7, 10);
        chk("c5.const_wt", 32'(weight), 0);

        // 6: reset in the middle of enumeration
        for (int i = 0; i < MR; i++) rref_v[i] = '0;
        @(negedge clk);
        rows  = 3'd4;
        cols  = 3'd7;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (30) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("c6.ready", 32'(ready), 1);
        chk("c6.done", 32'(done), 0);
        chk("c6.solution", 32'(solution), 0);
        chk("c6.weight", 32'(weight), 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        saw = 1'b0;
        repeat (80) begin
            @(posedge clk); #1;
            if (done === 1'b1) saw = 1'b1;
        end
        chk("c6.no_done", 32'(saw), 0);
        rref_v[0] = 7'b0001001;
        rref_v[1] = 7'b0000010;
        rref_v[2] = 7'b0001100;
        rref_v[3] = 7'b0000000;
        run_case("c6.after", 3, 4, 0);

        // random RREF systems
        for (int t = 0; t < 40; t++) begin
            gen(r_n, c_n);
            run_case($sformatf("rnd%0d", t), r_n, c_n, ($urandom_range(0, 3) == 0) ? 2 : 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
